// File: rtl/fp_align_ctrl.sv
// fp_align_ctrl: exponent compare and serial mantissa alignment ahead of the mantissa add/sub stage
module fp_align_ctrl #(
    parameter int EXP_SIZE = 8,
    parameter int MAN_SIZE = 24,
    parameter logic [1:0] EQUAL = 2'b00,
    parameter logic [1:0] GREAT = 2'b01,
    parameter logic [1:0] SMALL = 2'b10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_start,
    input  logic [EXP_SIZE-1:0] in_exp_A,
    input  logic [EXP_SIZE-1:0] in_exp_B,
    input  logic [MAN_SIZE-1:0] in_man_A,
    input  logic [MAN_SIZE-1:0] in_man_B,
    output logic                out_busy,
    output logic                out_done,
    output logic [1:0]          out_code,
    output logic [EXP_SIZE-1:0] out_exp,
    output logic [MAN_SIZE-1:0] out_man_A,
    output logic [MAN_SIZE-1:0] out_man_B,
    output logic                out_sticky
);
    localparam logic [1:0] S_IDLE = 2'd0, S_CMP = 2'd1, S_SHIFT = 2'd2, S_DONE = 2'd3;
    logic [1:0]          state, code;
    logic [EXP_SIZE-1:0] exp_a, exp_b, cnt, diff;
    logic [MAN_SIZE-1:0] man_a, man_b;
    logic                sticky, a_lt_b, sat;
    always_comb begin
        a_lt_b = exp_a < exp_b;
        diff   = a_lt_b ? exp_b - exp_a : exp_a - exp_b;
        sat    = 32'(diff) > MAN_SIZE + 1;
    end
    assign out_busy   = state == S_CMP || state == S_SHIFT;
    assign out_done   = state == S_DONE;
    assign out_code   = code;
    assign out_exp    = a_lt_b ? exp_b : exp_a;
    assign out_man_A  = man_a;
    assign out_man_B  = man_b;
    assign out_sticky = sticky;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            code   <= '0;
            exp_a  <= '0;
            exp_b  <= '0;
            man_a  <= '0;
            man_b  <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (in_start) begin
                        exp_a  <= in_exp_A;
                        exp_b  <= in_exp_B;
                        man_a  <= in_man_A;
                        man_b  <= in_man_B;
                        sticky <= 1'b0;
                        state  <= S_CMP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CMP: begin
                    code <= (exp_a == exp_b) ? EQUAL : (a_lt_b ? GREAT : SMALL);
                    if (exp_a == exp_b) begin
                        state <= S_DONE;
                    end else if (sat) begin
                        // everything would be shifted out: collapse to the final result at once
                        if (a_lt_b) begin
                            man_a  <= '0;
                            sticky <= |man_a;
                            exp_a  <= exp_b;
                        end else begin
                            man_b  <= '0;
                            sticky <= |man_b;
                            exp_b  <= exp_a;
                        end
                        state <= S_DONE;
                    end else begin
                        cnt   <= diff;
                        state <= S_SHIFT;
                    end
                end
                default: begin
                    if (code == GREAT) begin
                        man_a  <= man_a >> 1;
                        sticky <= sticky | man_a[0];
                        exp_a  <= exp_a + 1'b1;
                    end else begin
                        man_b  <= man_b >> 1;
                        sticky <= sticky | man_b[0];
                        exp_b  <= exp_b + 1'b1;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == 1) state <= S_DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_align_ctrl.sv
// tb_fp_align_ctrl: directed vectors against an arithmetic model of the alignment result and timing
module tb_fp_align_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, in_start = 1'b0;
    logic [7:0]  in_exp_A = '0, in_exp_B = '0;
    logic [23:0] in_man_A = '0, in_man_B = '0;
    logic        out_busy, out_done, out_sticky;
    logic [1:0]  out_code;
    logic [7:0]  out_exp;
    logic [23:0] out_man_A, out_man_B;
    int          n_chk = 0, n_fail = 0, cyc = 0, dut_done_cyc = 0, m_lat = 0;
    logic        armed = 1'b0, active = 1'b0, m_sticky = 1'b0;
    logic [1:0]  m_code = '0;
    logic [7:0]  m_exp = '0;
    logic [23:0] m_man_a = '0, m_man_b = '0;

    fp_align_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_start(in_start),
        .in_exp_A(in_exp_A), .in_exp_B(in_exp_B), .in_man_A(in_man_A), .in_man_B(in_man_B),
        .out_busy(out_busy), .out_done(out_done), .out_code(out_code), .out_exp(out_exp),
        .out_man_A(out_man_A), .out_man_B(out_man_B), .out_sticky(out_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model(input logic [7:0] ea, input logic [7:0] eb, input logic [23:0] ma, input logic [23:0] mb);
        int d;
        logic [23:0] m, res;
        logic [63:0] mv;
        logic st;
        d = (ea > eb) ? int'(ea) - int'(eb) : int'(eb) - int'(ea);
        m = (ea < eb) ? ma : mb;
        mv = {40'd0, m};
        if (d == 0) begin
            res = m;
            st = 1'b0;
        end else if (d > 25) begin
            res = '0;
            st = |m;
        end else begin
            res = m >> d;
            st = (mv & ((64'd1 << d) - 64'd1)) != 64'd0;
        end
        m_code   = (d == 0) ? 2'b00 : ((ea < eb) ? 2'b01 : 2'b10);
        m_exp    = (ea > eb) ? ea : eb;
        m_lat    = (d == 0 || d > 25) ? 2 : 2 + d;
        m_man_a  = (ea < eb) ? res : ma;
        m_man_b  = (ea < eb) ? mb : res;
        m_sticky = st;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, out_busy, 0);
        chk({tag, "_done"}, out_done, 0);
        chk({tag, "_code"}, out_code, 0);
        chk({tag, "_exp"}, out_exp, 0);
        chk({tag, "_man_a"}, out_man_A, 0);
        chk({tag, "_man_b"}, out_man_B, 0);
        chk({tag, "_sticky"}, out_sticky, 0);
    endtask

    // one clock: advance the operation timeline, then sample 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        if (!rst_n) active = 1'b0;
        else if (armed) begin
            cyc = 1;
            active = 1'b1;
            dut_done_cyc = 0;
            armed = 1'b0;
        end else if (active) cyc++;
        #1;
        if (!rst_n) chk_zero("reset");
        else if (active) begin
            if (out_done && dut_done_cyc == 0) dut_done_cyc = cyc;
            chk("busy", out_busy, cyc < m_lat);
            chk("done", out_done, cyc == m_lat);
            if (cyc == m_lat) begin
                chk("code", out_code, m_code);
                chk("exp", out_exp, m_exp);
                chk("man_a", out_man_A, m_man_a);
                chk("man_b", out_man_B, m_man_b);
                chk("sticky", out_sticky, m_sticky);
                active = 1'b0;
            end
        end else begin
            chk("idle_busy", out_busy, 0);
            chk("idle_done", out_done, 0);
        end
    endtask

    task automatic go(input logic [7:0] ea, input logic [7:0] eb, input logic [23:0] ma, input logic [23:0] mb);
        in_exp_A = ea;
        in_exp_B = eb;
        in_man_A = ma;
        in_man_B = mb;
        in_start = 1'b1;
        armed = 1'b1;
        model(ea, eb, ma, mb);
        step();
        in_start = 1'b0;
    endtask

    task automatic run();
        int n = 0;
        while (active && n < 60) begin
            step();
            n++;
        end
        if (active) chk("timeout", 1, 0);
    endtask

    initial begin
        repeat (2) step();
        rst_n = 1'b1;
        step();
        go(8'h80, 8'h80, 24'h800000, 24'hC00000);
        run();
        chk("t1_lat", dut_done_cyc, 2);
        chk("t1_man_b", out_man_B, 24'hC00000);
        chk("t1_code", out_code, 2'b00);
        go(8'h81, 8'h84, 24'hC00001, 24'h800000);
        run();
        chk("t2_lat", dut_done_cyc, 5);
        chk("t2_man_a", out_man_A, 24'h180000);
        chk("t2_exp", out_exp, 8'h84);
        chk("t2_sticky", out_sticky, 1);
        go(8'h90, 8'h10, 24'h9ABCDE, 24'h000003);
        run();
        chk("t3_lat", dut_done_cyc, 2);
        chk("t3_man_b", out_man_B, 0);
        chk("t3_sticky", out_sticky, 1);
        step();
        go(8'h90, 8'h10, 24'h9ABCDE, 24'h000000);
        run();
        chk("t3b_sticky", out_sticky, 0);
        go(8'h99, 8'h80, 24'h123456, 24'h800000);
        run();
        chk("t4_lat", dut_done_cyc, 27);
        chk("t4_man_b", out_man_B, 0);
        chk("t4_sticky", out_sticky, 1);
        go(8'h9A, 8'h80, 24'h123456, 24'h800000);
        run();
        chk("t4b_lat", dut_done_cyc, 2);
        chk("t4b_exp", out_exp, 8'h9A);
        go(8'h81, 8'h84, 24'hC00001, 24'h800000);
        step();
        in_exp_A = 8'h10;
        in_exp_B = 8'h20;
        in_man_A = 24'hFFFFFF;
        in_man_B = 24'h000001;
        in_start = 1'b1;
        step();
        in_start = 1'b0;
        run();
        chk("t5_lat", dut_done_cyc, 5);
        chk("t5_man_a", out_man_A, 24'h180000);
        go(8'hFF, 8'hF0, 24'h800001, 24'hFFFFFF);
        run();
        chk("t6_man_b", out_man_B, 24'h0001FF);
        go(8'h05, 8'h06, 24'h000001, 24'h000000);
        run();
        go(8'h10, 8'h20, 24'h000000, 24'h400000);
        run();
        chk("t7_sticky", out_sticky, 0);
        step();
        go(8'h81, 8'h84, 24'hC00001, 24'h800000);
        step();
        step();
        #1 rst_n = 1'b0;
        active = 1'b0;
        #1 chk_zero("rst_async");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("post_rst_exp", out_exp, 0);
        go(8'h40, 8'h42, 24'h000003, 24'h000001);
        run();
        chk("t8_lat", dut_done_cyc, 4);
        chk("t8_man_a", out_man_A, 0);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_align_ctrl.md
Name: fp_align_ctrl

Overview:
Sequential exponent-alignment controller for the floating-point adder path. It compares two operand exponents using the team's 2-bit compare encoding. It then right-shifts the mantissa of the smaller-exponent operand one bit per cycle until the exponents match, accumulating a sticky bit. Its output feeds the mantissa add/sub stage, together with the common exponent and the compare code.

Parameters:
EXP_SIZE, 8, exponent width in bits
MAN_SIZE, 24, mantissa width in bits, including the hidden bit
EQUAL, 2'b00, compare code: exp_A == exp_B
GREAT, 2'b01, compare code: exp_A < exp_B (B is larger; A is shifted)
SMALL, 2'b10, compare code: exp_A > exp_B (A is larger; B is shifted)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active-low
in_start  input  1  request; operands sampled on the accepting edge
in_exp_A  input  EXP_SIZE  exponent of operand A
in_exp_B  input  EXP_SIZE  exponent of operand B
in_man_A  input  MAN_SIZE  mantissa of operand A
in_man_B  input  MAN_SIZE  mantissa of operand B
out_busy  output  1  high in COMPARE and SHIFT
out_done  output  1  one-cycle pulse; results valid
out_code  output  2  latched exponent compare code
out_exp  output  EXP_SIZE  common (larger) exponent
out_man_A  output  MAN_SIZE  aligned mantissa A
out_man_B  output  MAN_SIZE  aligned mantissa B
out_sticky  output  1  OR of all bits shifted out of the smaller mantissa

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While rst_n=0: state=IDLE; all outputs and internal registers are 0.
- Reset mid-operation aborts immediately. No done pulse is produced. The next operation needs a fresh in_start after release.
- Internal registers: latched exponents expA/expB, mantissas manA/manB, shift counter cnt (EXP_SIZE bits), sticky.
- Output mapping: out_man_A, out_man_B, out_exp and out_sticky reflect the internal registers. out_exp = max(expA, expB).
- Held values: results hold after DONE until the next accepted start.
- IDLE:
  - busy=0.
  - in_start=1 latches all operands, clears sticky and moves to COMPARE.
- COMPARE (exactly 1 cycle, busy=1):
  - code = EQUAL if expA==expB; GREAT if expA<expB; else SMALL. Latch code into out_code.
  - EQUAL -> DONE.
  - Otherwise d = larger - smaller (unsigned, EXP_SIZE bits).
  - If d > MAN_SIZE+1 (saturation): smaller mantissa := 0; sticky := OR of its bits; smaller exponent := larger; go to DONE.
  - Else cnt := d, go to SHIFT.
- SHIFT (busy=1), each cycle:
  - smaller mantissa >>= 1, zero-filled.
  - sticky |= bit shifted out.
  - smaller exponent += 1.
  - cnt -= 1.
  - The cycle in which cnt goes 1 -> 0 transitions to DONE.
- DONE (busy=0): out_done=1 for exactly this cycle.
  - in_start=1 here is accepted exactly as in IDLE (back-to-back), going to COMPARE.
  - Otherwise go to IDLE.
- in_start while busy=1 is ignored; latched operands are unchanged.
- Latency, counted from the accepting edge = cycle 0:
  - out_done high in cycle 2 for EQUAL or saturation.
  - out_done high in cycle 2+d for 1 <= d <= MAN_SIZE+1.
  - Maximum is MAN_SIZE+3.
- Boundary cases:
  - d = MAN_SIZE+1 uses the full shift path: mantissa ends at 0, sticky = OR(original).
  - A zero mantissa always yields sticky=0.
  - Exponent arithmetic never wraps: the smaller exponent only increments up to the larger one.

Test Plan:
1. Equal exponents: exp_A=exp_B=0x80, man_A=0x800000, man_B=0xC00000 -> code=00, done at cycle 2, mantissas unchanged, out_exp=0x80, sticky=0.
2. Shift A: exp_A=0x81, exp_B=0x84, man_A=0xC00001, man_B=0x800000 -> code=01, busy cycles 1-4, done at cycle 5, out_man_A=0x180000, out_man_B=0x800000, out_exp=0x84, sticky=1.
3. Saturation: exp_A=0x90, exp_B=0x10, man_B=0x000003 -> code=10, done at cycle 2, out_man_B=0, sticky=1, out_exp=0x90. Repeat with man_B=0 -> sticky=0.
4. Threshold: d=25, man_B=0x800000 -> full shift, done at cycle 27, out_man_B=0, sticky=1. Then d=26 -> saturation path, done at cycle 2.
5. Handshake:
   - in_start pulsed during SHIFT with different operands -> ignored; results match the first operation.
   - in_start in the DONE cycle -> second operation's done at the expected latency after that edge.
6. Reset: rst_n=0 in the 2nd SHIFT cycle of scenario 2 -> all outputs 0 asynchronously (before the next clk edge), no done pulse. After release with in_start low, stays IDLE.
